led_pattern_gen: RTL and testbench

- Multi-channel successor to the single free-running LED blink counter.
- Shared prescaler and phase counter drive CHANNELS independent LED outputs.
- Each channel is programmed through a simple write port to one of four modes: off, on, blink or PWM.
- Used as a small sequential benchmark and as the board status-LED driver.

---
 rtl/led_cfg_if.sv | 12 +
 rtl/led_pattern_gen.sv | 76 +++++++
 tb/tb_led_pattern_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/led_cfg_if.sv
// led_cfg_if: channel configuration write port for led_pattern_gen
interface led_cfg_if #(
    parameter int CH_W  = 2,
    parameter int PWM_W = 4
);
    logic             wr_en;
    logic [CH_W-1:0]  wr_chan;
    logic [1:0]       wr_mode;
    logic [PWM_W-1:0] wr_duty;
    modport master (output wr_en, wr_chan, wr_mode, wr_duty);
    modport slave  (input  wr_en, wr_chan, wr_mode, wr_duty);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: shared prescaler/phase driving per-channel off/on/blink/pwm LEDs
// Define LED_BREATHE_EN to turn mode 3 into a triangle-wave breathe effect.
module led_pattern_gen #(
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8,
    parameter int PWM_W      = 4,
    parameter int CH_W       = 2
) (
    input  logic                clk,
    input  logic                rst,
    led_cfg_if.slave            cfg,
    output logic [CHANNELS-1:0] led,
    output logic                tick
);
    localparam logic [CH_W:0] NCH = (CH_W+1)'(CHANNELS);
    logic [PRESCALE_W-1:0] presc;
    logic [PWM_W-1:0]      phase;
    logic                  p_max;
    logic                  wr_ok;
    assign p_max = &presc;
    assign wr_ok = cfg.wr_en && ({1'b0, cfg.wr_chan} < NCH);
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            phase <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            tick  <= p_max;
            if (p_max) phase <= phase + 1'b1;
        end
    end
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]       mode;
        logic [PWM_W-1:0] duty;
        logic             wr;
        logic             pwm;
        logic             led_q;
        assign wr = wr_ok && (cfg.wr_chan == CH_W'(i));
`ifdef LED_BREATHE_EN
        logic [PWM_W-1:0] level;
        logic [PWM_W-1:0] target;
        logic [PWM_W-1:0] nlevel;
        logic             up;
        assign target = up ? duty : '0;
        assign nlevel = level < target ? level + 1'b1 : level > target ? level - 1'b1 : level;
        // level restarts whenever the channel is (re)entered into mode 3 or is not breathing
        always_ff @(posedge clk) begin
            if (rst || (wr && cfg.wr_mode == 2'd3) || mode != 2'd3) begin
                level <= '0;
                up    <= 1'b1;
            end else if (p_max && &phase) begin
                level <= nlevel;
                if (nlevel == target) up <= !up;
            end
        end
        assign pwm = phase < level;
`else
        assign pwm = (phase < duty) || (&duty);
`endif
        always_ff @(posedge clk) begin
            if (rst) begin
                mode  <= '0;
                duty  <= '0;
                led_q <= 1'b0;
            end else begin
                if (wr) begin
                    mode <= cfg.wr_mode;
                    duty <= cfg.wr_duty;
                end
                led_q <= mode == 2'd0 ? 1'b0 : mode == 2'd1 ? 1'b1 : mode == 2'd2 ? phase[PWM_W-1] : pwm;
            end
        end
        assign led[i] = led_q;
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: randomized bench with an arithmetic reference model for led_pattern_gen
module tb_led_pattern_gen;
    localparam int CHN = 4, PW = 2, DW = 3, CW = 3;
    localparam int PER = 32;
    logic clk = 1'b0;
    logic rst;
    logic [CHN-1:0] led;
    logic tick;
    int checks = 0, failures = 0;
    led_cfg_if #(.CH_W(CW), .PWM_W(DW)) cfg ();
    led_pattern_gen #(.CHANNELS(CHN), .PRESCALE_W(PW), .PWM_W(DW), .CH_W(CW)) dut (
        .clk(clk), .rst(rst), .cfg(cfg), .led(led), .tick(tick)
    );
    always #5 clk = ~clk;
    // reference model: n = clocks since reset release, k = phase wraps since last mode-3 write
    int n;
    int mode_m [CHN];
    int duty_m [CHN];
    int k_m [CHN];
    logic [CHN-1:0] exp_led;
    logic exp_tick;
    logic valid = 1'b0;
    function automatic int lvl(int i);
        int d, r;
        d = duty_m[i];
        if (d == 0) return 0;
        r = k_m[i] % (2 * d);
        return r <= d ? r : 2 * d - r;
    endfunction
    function automatic logic model_led(int i, int ph);
        case (mode_m[i])
            0: return 1'b0;
            1: return 1'b1;
            2: return ph >= 4;
            default: begin
`ifdef LED_BREATHE_EN
                return ph < lvl(i);
`else
                return duty_m[i] == 7 || ph < duty_m[i];
`endif
            end
        endcase
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            n = 0;
            exp_led = '0;
            exp_tick = 1'b0;
            for (int i = 0; i < CHN; i++) begin
                mode_m[i] = 0;
                duty_m[i] = 0;
                k_m[i] = 0;
            end
        end else begin
            exp_tick = (n % 4) == 3;
            for (int i = 0; i < CHN; i++) begin
                exp_led[i] = model_led(i, (n / 4) % 8);
                if (mode_m[i] == 3 && (n % PER) == PER - 1) k_m[i]++;
            end
            if (cfg.wr_en && cfg.wr_chan < CHN) begin
                mode_m[cfg.wr_chan] = cfg.wr_mode;
                duty_m[cfg.wr_chan] = cfg.wr_duty;
                k_m[cfg.wr_chan] = 0;
            end
            n++;
        end
        valid = 1'b1;
    end
    always @(negedge clk) begin
        if (valid) begin
            checks++;
            if (led !== exp_led || tick !== exp_tick) begin
                failures++;
                $display("FAIL model t=%0t led=%b tick=%b expected led=%b tick=%b", $time, led, tick, exp_led, exp_tick);
            end
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask
    task automatic wr(input int ch, input int md, input int dt);
        @(negedge clk);
        cfg.wr_en = 1'b1;
        cfg.wr_chan = CW'(ch);
        cfg.wr_mode = 2'(md);
        cfg.wr_duty = DW'(dt);
        @(negedge clk);
        cfg.wr_en = 1'b0;
    endtask
    task automatic wr_at_wrap(input int ch, input int md, input int dt);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while ((n % PER) != PER - 1 && b < 2 * PER);
        chk("wrap_wait", int'(b < 2 * PER), 1);
        cfg.wr_en = 1'b1;
        cfg.wr_chan = CW'(ch);
        cfg.wr_mode = 2'(md);
        cfg.wr_duty = DW'(dt);
        @(negedge clk);
        cfg.wr_en = 1'b0;
    endtask
    task automatic count_hi(input int ch, output int c);
        c = 0;
        repeat (PER) begin
            @(negedge clk);
            c += int'(led[ch]);
        end
    endtask
    initial begin
        int c, d;
        logic [7:0] tv;
        logic [CHN-1:0] save;
        rst = 1'b1;
        cfg.wr_en = 1'b0;
        cfg.wr_chan = '0;
        cfg.wr_mode = '0;
        cfg.wr_duty = '0;
        repeat (3) @(negedge clk);
        chk("reset_led", int'(led), 0);
        chk("reset_tick", int'(tick), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tv[i] = tick;
        end
        chk("tick_pattern", int'(tv), 8'b1000_1000);
        wr(1, 1, 0);
        chk("on_not_yet", int'(led[1]), 0);
        @(negedge clk);
        chk("on_visible", int'(led[1]), 1);
        wr(1, 0, 0);
        @(negedge clk);
        chk("off_visible", int'(led[1]), 0);
        wr(1, 1, 0);
        repeat (2) @(negedge clk);
        save = led;
        wr(5, 0, 0);
        wr(4, 2, 0);
        repeat (2) @(negedge clk);
        chk("bad_chan", int'(led), int'(save));
        chk("bad_chan_ch1", int'(led[1]), 1);
        wr(1, 0, 0);
        wr(0, 2, 0);
        wr(3, 2, 0);
        c = 0;
        d = 0;
        repeat (PER) begin
            @(negedge clk);
            c += int'(led[0]);
            d += int'(led[0] != led[3]);
        end
        chk("blink_high", c, 16);
        chk("blink_align", d, 0);
        wr_at_wrap(2, 3, 3);
`ifdef LED_BREATHE_EN
        begin
            int exp_hi [8] = '{0, 4, 8, 12, 8, 4, 0, 4};
            for (int p = 0; p < 8; p++) begin
                count_hi(2, c);
                chk($sformatf("breathe_p%0d", p), c, exp_hi[p]);
            end
        end
`else
        count_hi(2, c);
        chk("pwm_duty3", c, 12);
        wr(2, 3, 0);
        count_hi(2, c);
        chk("pwm_duty0", c, 0);
        wr(2, 3, 7);
        count_hi(2, c);
        chk("pwm_duty7", c, PER);
`endif
        wr(2, 3, 5);
        count_hi(0, c);
        chk("blink_isolated", c, 16);
        @(negedge clk);
        rst = 1'b1;
        cfg.wr_en = 1'b1;
        cfg.wr_chan = 3'd1;
        cfg.wr_mode = 2'd1;
        @(negedge clk);
        rst = 1'b0;
        cfg.wr_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_priority", int'(led), 0);
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom % 400) == 0;
            cfg.wr_en = ($urandom % 6) == 0;
            cfg.wr_chan = CW'($urandom % 8);
            cfg.wr_mode = 2'($urandom % 4);
            cfg.wr_duty = DW'($urandom % 8);
        end
        @(negedge clk);
        rst = 1'b0;
        cfg.wr_en = 1'b0;
        repeat (PER) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
